if_stage_fq: RTL and testbench
==============================

Name: if_stage_fq

Overview:
- Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue between instruction memory and decode.
- Decouples the fetch rate from decode stalls, since fetches continue while decode holds.
- Supports one outstanding memory read, redirect with in-flight squash, halt, and sticky error reporting.
- Sits between the PC/branch-resolution logic and the ID stage. It drives the cache-based instruction memory through a Rd/Done/Stall handshake.

Parameters:
- WIDTH, 16, instruction and address width in bits.
- DEPTH, 4, prefetch queue entries (power of two, >=2).
- RESET_PC, 0, PC value after reset.
- PC_INC, 2, sequential PC increment.
- NOP, 16'h0800, instruction presented to decode when no valid entry.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  WIDTH  target PC when redirect=1.
- hold  in  1  decode not consuming this cycle (hazard or dmem stall).
- halt_n  in  1  0 = stop issuing new fetches.
- imem_addr  out  WIDTH  fetch address.
- imem_rd  out  1  read request.
- imem_stall  in  1  memory busy; request not accepted.
- imem_done  in  1  read data valid this cycle.
- imem_data  in  WIDTH  returned instruction.
- imem_err  in  1  memory error, qualified by imem_done.
- Inst  out  WIDTH  head instruction, or NOP.
- PCAdd2  out  WIDTH  head entry PC + PC_INC.
- inst_valid  out  1  Inst is a real fetched instruction.
- err  out  1  sticky error.

Behaviour:
- Reset (async, rst=1): PC=RESET_PC, queue empty, inflight=0, squash=0, err=0, state IDLE. Outputs during reset: imem_rd=0, inst_valid=0, Inst=NOP, PCAdd2=0.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request accepted, awaiting imem_done.
  - HALTED: halt_n seen low with no request outstanding.
- Issue condition: state IDLE, halt_n=1, redirect=0, and count+inflight < DEPTH. A pop in the same cycle is not credited.
- On issue: imem_rd=1, imem_addr=PC.
- Acceptance: when imem_stall=0 the request is accepted. The stage captures pc_req=PC, sets PC=PC+PC_INC (mod 2^WIDTH) and moves to WAIT. When imem_stall=1, imem_rd and imem_addr are held stable and the request is retried next cycle.
- WAIT with imem_done=1 and squash=0: push {imem_data, pc_req+PC_INC} into the queue, then go to IDLE. Data is visible on Inst the next cycle (no bypass).
- WAIT with imem_done=1 and squash=1: discard the data, clear squash, go to IDLE.
- Pop: occurs when inst_valid=1, hold=0 and redirect=0. The head advances at the clock edge.
- Outputs from queue state: queue empty gives inst_valid=0 and Inst=NOP; otherwise inst_valid=1 and Inst/PCAdd2 come from the head entry (combinational from queue state).
- Redirect (highest priority):
  - Queue cleared and PC=redirect_pc.
  - If WAIT, squash=1. If the same cycle also has imem_done, that data is discarded and squash is not set.
  - No issue in the redirect cycle; the first fetch of redirect_pc is issued the next cycle.
  - Inst=NOP and inst_valid=0 during the redirect cycle.
- Halt: with halt_n=0 no new issue occurs. An outstanding read completes normally, the queue drains under hold=0, and the FSM enters HALTED. halt_n=1 returns to IDLE. A redirect while HALTED updates PC and remains HALTED.
- Errors: err is set on imem_done & imem_err & ~squash, or on an accepted issue with PC[0]=1. err clears only on rst.
- Boundary cases:
  - Full queue: no issue.
  - Push and pop in the same cycle: count is unchanged.
  - PC wraps from 2^WIDTH-PC_INC to 0.
  - rst asserted mid-WAIT: all state clears immediately. The memory is reset by the same rst.

Decomposition:
- Package if_pkg:
  - FSM state typedef {IDLE, WAIT, HALTED}.
  - NOP default constant.
  - Queue entry struct {inst, pc_next}.
- Sub-module fetch_queue:
  - Synchronous FIFO of DEPTH entries, 2*WIDTH wide, with clear.
  - Ports: push, pop, clr, count, empty, full.

Test Plan:
- Reset, memory latency 1 cycle, hold=0 → first imem_rd at addr 0x0000 in the cycle after rst deasserts. Inst=NOP until the done+1 cycle, then fetched data with PCAdd2=0x0002, then addresses 0x0002, 0x0004.
- hold=1 for 10 cycles → exactly 4 fetches issued; queue full; imem_rd=0. Release hold → 4 entries drain in order with PCAdd2 0x0002..0x0008.
- Redirect to 0x0040 while WAIT, done arrives next cycle → that data discarded, queue empty. Next issue at 0x0040 and first valid Inst has PCAdd2=0x0042.
- imem_stall=1 for 3 cycles on the first issue → imem_addr held at 0x0000 with imem_rd=1. PC is unchanged until acceptance.
- halt_n=0 during WAIT → the in-flight instruction is pushed and no further imem_rd occurs. After drain, inst_valid=0 and the FSM is HALTED.
- imem_err=1 with done → err=1 and stays 1 across a redirect. rst asserted mid-WAIT → err=0, Inst=NOP, PC=RESET_PC asynchronously.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage and its prefetch queue.
package if_pkg;
  localparam int unsigned IF_WIDTH = 16;
  localparam logic [IF_WIDTH-1:0] NOP_DEFAULT = 16'h0800;

  typedef enum logic [1:0] {IDLE, WAIT, HALTED} fetch_state_t;

  // Queue entry layout at the default width: instruction in the upper half.
  typedef struct packed {
    logic [IF_WIDTH-1:0] inst;
    logic [IF_WIDTH-1:0] pc_next;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {inst, pc_next} pairs; clr empties it in one cycle.
module fetch_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/if_stage_fq.sv
// Instruction-fetch stage: one outstanding imem read feeding a prefetch queue toward decode.
module if_stage_fq
  import if_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      PC_INC   = 2,
  parameter logic [WIDTH-1:0] NOP      = WIDTH'(NOP_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             hold,
  input  logic             halt_n,
  output logic [WIDTH-1:0] imem_addr,
  output logic             imem_rd,
  input  logic             imem_stall,
  input  logic             imem_done,
  input  logic [WIDTH-1:0] imem_data,
  input  logic             imem_err,
  output logic [WIDTH-1:0] Inst,
  output logic [WIDTH-1:0] PCAdd2,
  output logic             inst_valid,
  output logic             err
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t       state;
  logic [WIDTH-1:0]   pc;
  logic [WIDTH-1:0]   pc_req;
  logic               squash;
  logic [2*WIDTH-1:0] head;
  logic [2*WIDTH-1:0] din;
  logic [CW-1:0]      count;
  logic               empty;
  logic               full;
  logic               issue;
  logic               accept;
  logic               done_w;
  logic               push;
  logic               pop;

  // A pop in the same cycle does not free a slot for issue.
  assign issue  = !rst && (state == IDLE) && halt_n && !redirect && (32'(count) < DEPTH);
  assign accept = issue && !imem_stall;
  assign done_w = (state == WAIT) && imem_done;
  assign push   = done_w && !squash && !redirect && !full;

  assign imem_rd    = issue;
  assign imem_addr  = pc;
  assign inst_valid = !empty && !redirect;
  assign pop        = inst_valid && !hold;
  assign Inst       = inst_valid ? head[2*WIDTH-1:WIDTH] : NOP;
  assign PCAdd2     = inst_valid ? head[WIDTH-1:0] : '0;
  assign din        = {imem_data, pc_req + WIDTH'(PC_INC)};

  fetch_queue #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clr   (redirect),
    .din   (din),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Fetch control: redirect overrides everything; err is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      pc_req <= '0;
      squash <= 1'b0;
      err    <= 1'b0;
    end else begin
      if ((done_w && imem_err && !squash) || (accept && pc[0])) err <= 1'b1;
      if (redirect) begin
        pc <= redirect_pc;
        if (state == WAIT) begin
          if (imem_done) begin
            state  <= IDLE;
            squash <= 1'b0;
          end else begin
            squash <= 1'b1;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            if (!halt_n) begin
              state <= HALTED;
            end else if (accept) begin
              pc_req <= pc;
              pc     <= pc + WIDTH'(PC_INC);
              state  <= WAIT;
            end
          end
          WAIT: begin
            if (imem_done) begin
              state  <= IDLE;
              squash <= 1'b0;
            end
          end
          HALTED: if (halt_n) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_if_stage_fq.sv
// Scoreboard bench for if_stage_fq: issued fetches queue expectations, a monitor checks pops.
module tb_if_stage_fq;
  localparam logic [15:0] NOP = 16'h0800;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        hold;
  logic        halt_n;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic        imem_stall;
  logic        imem_done;
  logic [15:0] imem_data;
  logic        imem_err;
  logic [15:0] Inst;
  logic [15:0] PCAdd2;
  logic        inst_valid;
  logic        err;

  if_stage_fq dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hold        (hold),
    .halt_n      (halt_n),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_stall  (imem_stall),
    .imem_done   (imem_done),
    .imem_data   (imem_data),
    .imem_err    (imem_err),
    .Inst        (Inst),
    .PCAdd2      (PCAdd2),
    .inst_valid  (inst_valid),
    .err         (err)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_acc = 0;
  int          lat = 1;
  int          cnt = 0;
  int          snap;
  logic        pend = 0;
  logic        inj_err = 0;
  logic        last_acc = 0;
  logic [15:0] pend_addr = '0;
  logic [15:0] pc_exp = '0;
  logic [31:0] exp_q[$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample acceptance at negedge, then drive the memory response after posedge.
  task automatic tick();
    @(negedge clk);
    last_acc = 0;
    if (!rst && imem_rd && !imem_stall) begin
      last_acc = 1;
      n_acc++;
      chk("issue_addr", imem_addr, pc_exp);
      exp_q.push_back({mem_word(pc_exp), pc_exp + 16'd2});
      pc_exp    = pc_exp + 16'd2;
      pend      = 1;
      cnt       = lat;
      pend_addr = imem_addr;
    end
    @(posedge clk);
    #1;
    imem_done = 0;
    imem_err  = 0;
    if (rst) begin
      pend = 0;
    end else if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_done = 1;
        imem_data = mem_word(pend_addr);
        imem_err  = inj_err;
        inj_err   = 0;
        pend      = 0;
      end
    end
  endtask

  task automatic wait_acc();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    chk("acc_timeout", 32'(last_acc), 1);
  endtask

  task automatic do_reset();
    rst = 1;
    exp_q.delete();
    pc_exp = '0;
    pend = 0;
    imem_done = 0;
    imem_err = 0;
    #1;
    chk("rst_rd", imem_rd, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", Inst, NOP);
    chk("rst_pcadd2", PCAdd2, 0);
    chk("rst_err", err, 0);
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  task automatic do_redirect(input logic [15:0] t);
    redirect = 1;
    redirect_pc = t;
    exp_q.delete();
    pc_exp = t;
    #1;
    chk("redir_valid", inst_valid, 0);
    chk("redir_inst", Inst, NOP);
    chk("redir_rd", imem_rd, 0);
    tick();
    redirect = 0;
    #1;
  endtask

  // Monitor: every pop must match the oldest outstanding expectation.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (inst_valid && !hold) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL pop_unexpected: got inst %0h pcadd2 %0h with nothing expected", Inst, PCAdd2);
          end else begin
            e = exp_q.pop_front();
            chk("pop_inst", Inst, {16'h0, e[31:16]});
            chk("pop_pcadd2", PCAdd2, {16'h0, e[15:0]});
          end
        end else if (!inst_valid) begin
          chk("idle_inst", Inst, NOP);
          chk("idle_pcadd2", PCAdd2, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; redirect = 0; redirect_pc = '0; hold = 0; halt_n = 1;
    imem_stall = 0; imem_done = 0; imem_data = '0; imem_err = 0;

    // Basic fetch with 1-cycle memory
    do_reset();
    chk("t1_rd", imem_rd, 1);
    chk("t1_addr", imem_addr, 16'h0000);
    tick();
    chk("t1_wait_rd", imem_rd, 0);
    chk("t1_wait_valid", inst_valid, 0);
    tick();
    chk("t1_valid", inst_valid, 1);
    chk("t1_inst", Inst, mem_word(16'h0000));
    chk("t1_pcadd2", PCAdd2, 16'h0002);
    chk("t1_next_addr", imem_addr, 16'h0002);
    for (int i = 0; i < 6; i++) tick();

    // Hold fills the queue, then drain in order
    hold = 1;
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("t2_fetches", 32'(n_acc), 4);
    chk("t2_full_rd", imem_rd, 0);
    chk("t2_head", Inst, mem_word(16'h0000));
    hold = 0;
    for (int i = 0; i < 8; i++) tick();

    // Redirect while WAIT squashes the late data
    lat = 2;
    wait_acc();
    do_redirect(16'h0040);
    chk("t3_sq_valid", inst_valid, 0);
    chk("t3_sq_rd", imem_rd, 0);
    tick();
    chk("t3_rd", imem_rd, 1);
    chk("t3_addr", imem_addr, 16'h0040);
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (inst_valid) break;
    end
    chk("t3_first_valid", inst_valid, 1);
    chk("t3_pcadd2", PCAdd2, 16'h0042);

    // PC wrap
    do_redirect(16'hFFFE);
    wait_acc();
    wait_acc();
    for (int i = 0; i < 4; i++) tick();

    // Stall on first issue
    imem_stall = 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_rd", imem_rd, 1);
      chk("t4_stall_addr", imem_addr, 16'h0000);
      tick();
    end
    imem_stall = 0;
    tick();
    chk("t4_accepted_rd", imem_rd, 0);
    wait_acc();

    // Halt during WAIT
    wait_acc();
    halt_n = 0;
    #1;
    chk("t5_wait_rd", imem_rd, 0);
    tick();
    snap = n_acc;
    for (int i = 0; i < 6; i++) tick();
    chk("t5_no_fetch", 32'(n_acc), 32'(snap));
    chk("t5_halt_rd", imem_rd, 0);
    chk("t5_drained", inst_valid, 0);
    halt_n = 1;
    #1;
    chk("t5_halted_rd", imem_rd, 0);
    tick();
    chk("t5_resume_rd", imem_rd, 1);

    // Sticky error, reset mid-WAIT, odd PC
    chk("t6_err0", err, 0);
    inj_err = 1;
    wait_acc();
    tick();
    chk("t6_err_set", err, 1);
    do_redirect(16'h0100);
    chk("t6_err_sticky", err, 1);
    lat = 2;
    wait_acc();
    rst = 1;
    #1;
    chk("t6_rst_err", err, 0);
    chk("t6_rst_inst", Inst, NOP);
    chk("t6_rst_valid", inst_valid, 0);
    chk("t6_rst_rd", imem_rd, 0);
    do_reset();
    chk("t6_pc_rd", imem_rd, 1);
    chk("t6_pc_addr", imem_addr, 16'h0000);
    lat = 1;
    do_redirect(16'h0011);
    wait_acc();
    chk("t6_odd_err", err, 1);

    halt_n = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("end_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
